// File: rtl/simon_pkg.sv
// Shared constants and state encoding for the Simon sequencer and its LFSR.
package simon_pkg;

   localparam int LFSR_W = 16;
   localparam logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1;
   // Right-shift Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1 (period 65535).
   localparam logic [LFSR_W-1:0] LFSR_TAPS = 16'h002D;

   typedef enum logic [2:0] {
      S_IDLE,
      S_EXTEND,
      S_PLAY_ON,
      S_PLAY_GAP,
      S_AWAIT,
      S_WIN,
      S_LOSE
   } state_t;

   function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
      return {^(s & LFSR_TAPS), s[LFSR_W-1:1]};
   endfunction

endpackage

// File: rtl/simon_lfsr.sv
// Free-running 16-bit maximal-length LFSR; seeded on reset, steps when enabled.
module simon_lfsr import simon_pkg::*; #(
   parameter int OUT_W = 2
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_en,
   output logic [OUT_W-1:0] o_bits
);

   logic [LFSR_W-1:0] r_state;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= LFSR_SEED;
      end else if (i_en) begin
         r_state <= lfsr_next(r_state);
      end
   end

   assign o_bits = r_state[OUT_W-1:0];

endmodule

// File: rtl/simon_sequencer.sv
// Simon memory game sequencer: grows a random sequence, plays it back, checks the player.
// Build option SIMON_TIMEOUT_EN: lose when the player idles TIMEOUT_CYCLES in AWAIT.
//
// state      | meaning
// S_IDLE     | waiting for START, LFSR free-running
// S_EXTEND   | append one random symbol, LEVEL++
// S_PLAY_ON  | sounding sequence note for TONE_CYCLES
// S_PLAY_GAP | silence for GAP_CYCLES between notes
// S_AWAIT    | accepting and checking player presses
// S_WIN      | all DEPTH rounds done, WIN held
// S_LOSE     | wrong press or timeout, LOSE held
module simon_sequencer import simon_pkg::*; #(
   parameter int DATA_WIDTH     = 2,
   parameter int DEPTH          = 16,
   parameter int TONE_CYCLES    = 12_000_000,
   parameter int GAP_CYCLES     = 6_000_000,
   parameter int TIMEOUT_CYCLES = 150_000_000
) (
   input  logic                       CLK,
   input  logic                       RST,
   input  logic                       START,
   input  logic                       BTN_VALID,
   input  logic [DATA_WIDTH-1:0]      BTN,
   output logic [DATA_WIDTH-1:0]      NOTE,
   output logic                       NOTE_ON,
   output logic [$clog2(DEPTH+1)-1:0] LEVEL,
   output logic                       AWAIT,
   output logic                       WIN,
   output logic                       LOSE
);

   localparam int LW    = $clog2(DEPTH + 1);
   localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int TMAX1 = (TONE_CYCLES > GAP_CYCLES) ? TONE_CYCLES : GAP_CYCLES;
   localparam int TMAX  = (TMAX1 > TIMEOUT_CYCLES) ? TMAX1 : TIMEOUT_CYCLES;
   localparam int TW    = $clog2(TMAX + 1);

   state_t                r_state;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [LW-1:0]         r_level;
   logic [IW-1:0]         r_idx;
   logic [TW-1:0]         r_timer;
   logic [DATA_WIDTH-1:0] r_note;
   logic                  r_note_on;
   logic                  r_await;
   logic                  r_win;
   logic                  r_lose;

   logic [DATA_WIDTH-1:0] w_sym;
   logic                  w_lfsr_en;
   logic [LW-1:0]         w_idx_l;
   logic [IW-1:0]         w_idx_nxt;
   logic                  w_last;
   logic                  w_more;

   assign w_lfsr_en = (r_state == S_IDLE) || (r_state == S_EXTEND);
   assign w_idx_l   = LW'(r_idx);
   assign w_idx_nxt = r_idx + IW'(1);
   assign w_last    = (w_idx_l == r_level - LW'(1));
   assign w_more    = ((w_idx_l + LW'(1)) < r_level);

   simon_lfsr #(.OUT_W(DATA_WIDTH)) u_lfsr (
      .i_clk  (CLK),
      .i_rst  (RST),
      .i_en   (w_lfsr_en),
      .o_bits (w_sym)
   );

   // Sequence memory survives reset so only the FSM state gates its contents.
   always_ff @(posedge CLK) begin
      if (!RST && (r_state == S_EXTEND)) begin
         r_mem[r_level[IW-1:0]] <= w_sym;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_level   <= '0;
         r_idx     <= '0;
         r_timer   <= '0;
         r_note    <= '0;
         r_note_on <= 1'b0;
         r_await   <= 1'b0;
         r_win     <= 1'b0;
         r_lose    <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
               if (START) begin
                  r_state   <= S_EXTEND;
                  r_level   <= '0;
                  r_idx     <= '0;
                  r_win     <= 1'b0;
                  r_lose    <= 1'b0;
                  r_note_on <= 1'b0;
               end
            end
            S_EXTEND: begin
               r_level   <= r_level + LW'(1);
               r_idx     <= '0;
               // Slot 0 is still being written when this is the first round.
               r_note    <= (r_level == '0) ? w_sym : r_mem[0];
               r_note_on <= 1'b1;
               r_timer   <= TW'(TONE_CYCLES - 1);
               r_state   <= S_PLAY_ON;
            end
            S_PLAY_ON: begin
               if (r_timer == '0) begin
                  r_note_on <= 1'b0;
                  r_timer   <= TW'(GAP_CYCLES - 1);
                  r_state   <= S_PLAY_GAP;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            S_PLAY_GAP: begin
               if (r_timer == '0) begin
                  if (w_more) begin
                     r_idx     <= w_idx_nxt;
                     r_note    <= r_mem[w_idx_nxt];
                     r_note_on <= 1'b1;
                     r_timer   <= TW'(TONE_CYCLES - 1);
                     r_state   <= S_PLAY_ON;
                  end else begin
                     r_idx   <= '0;
                     r_await <= 1'b1;
                     r_timer <= TW'(TIMEOUT_CYCLES - 1);
                     r_state <= S_AWAIT;
                  end
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
            end
            S_AWAIT: begin
               r_note_on <= 1'b0;
               if (BTN_VALID) begin
                  if (BTN == r_mem[r_idx]) begin
                     r_note    <= BTN;
                     r_note_on <= 1'b1;
                     r_timer   <= TW'(TIMEOUT_CYCLES - 1);
                     if (w_last) begin
                        r_idx   <= '0;
                        r_await <= 1'b0;
                        if (r_level == LW'(DEPTH)) begin
                           r_win     <= 1'b1;
                           r_note_on <= 1'b0;
                           r_state   <= S_WIN;
                        end else begin
                           r_state <= S_EXTEND;
                        end
                     end else begin
                        r_idx <= w_idx_nxt;
                     end
                  end else begin
                     r_lose  <= 1'b1;
                     r_await <= 1'b0;
                     r_state <= S_LOSE;
                  end
               end
`ifdef SIMON_TIMEOUT_EN
               else if (r_timer == '0) begin
                  r_lose  <= 1'b1;
                  r_await <= 1'b0;
                  r_state <= S_LOSE;
               end else begin
                  r_timer <= r_timer - TW'(1);
               end
`else
`endif
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign NOTE    = r_note;
   assign NOTE_ON = r_note_on;
   assign LEVEL   = r_level;
   assign AWAIT   = r_await;
   assign WIN     = r_win;
   assign LOSE    = r_lose;

endmodule
